// File: rtl/axi4_lite_slave_read_sched_pkg.sv
// Shared types and constants for the AXI4-Lite slave read scheduler.
package axi4_lite_slave_read_sched_pkg;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  localparam int unsigned DEFAULT_MAX_DELAY_READY  = 16;
  localparam int unsigned DEFAULT_MAX_DELAY_RVALID = 10;

  typedef enum logic [1:0] {AR_IDLE, AR_WAIT, AR_READY} ar_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DELAY, R_VALID} r_state_t;

  function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/axi4_lite_sched_fifo.sv
// Outstanding-read address queue: power-of-2 depth, simultaneous push/pop.
module axi4_lite_sched_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/axi4_lite_slave_read_scheduler.sv
// AXI4-Lite read slave: AR acceptance with programmable ready delay, queued
// reads to a backing memory and R responses with programmable valid delay.
module axi4_lite_slave_read_scheduler
  import axi4_lite_slave_read_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned DEPTH            = 2,
  parameter int unsigned MAX_DELAY_READY  = DEFAULT_MAX_DELAY_READY,
  parameter int unsigned MAX_DELAY_RVALID = DEFAULT_MAX_DELAY_RVALID
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_default_ready,
  input  logic [4:0]                  cfg_arready_delay,
  input  logic [3:0]                  cfg_rvalid_delay,
  input  logic                        arvalid,
  input  logic [ADDR_WIDTH-1:0]       araddr,
  output logic                        arready,
  output logic                        rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic [1:0]                  rresp,
  input  logic                        rready,
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]       mem_rd_data,
  input  logic                        mem_rd_err,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_level
);

  localparam int unsigned ARC_W = $clog2(MAX_DELAY_READY + 1);
  localparam int unsigned RC_W  = $clog2(MAX_DELAY_RVALID + 1);

  ar_state_t             ar_state, ar_state_nx;
  logic [ARC_W-1:0]      ar_cnt, ar_cnt_nx;
  logic                  ar_en;
  int unsigned           ar_delay;

  r_state_t              r_state, r_state_nx;
  logic [RC_W-1:0]       r_cnt, r_cnt_nx;
  logic                  cap_pend;
  int unsigned           r_delay;

  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [ADDR_WIDTH-1:0] fifo_head;

  assign push   = arvalid && arready;
  assign rvalid = (r_state == R_VALID);

  axi4_lite_sched_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .push    (push),
    .wr_data (araddr),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // ar_en keeps arready low until the first clock edge after reset release.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ar_state <= AR_IDLE;
      ar_cnt   <= '0;
      ar_en    <= 1'b0;
    end else begin
      ar_state <= ar_state_nx;
      ar_cnt   <= ar_cnt_nx;
      ar_en    <= 1'b1;
    end
  end

  // AR_IDLE itself accounts for one delay cycle and AR_WAIT's zero count for
  // another, so the counter loads delay-2 and delays below 2 skip AR_WAIT.
  always_comb begin
    ar_state_nx = ar_state;
    ar_cnt_nx   = ar_cnt;
    arready     = 1'b0;
    ar_delay    = clamp_delay(32'(cfg_arready_delay), MAX_DELAY_READY);
    case (ar_state)
      AR_IDLE: begin
        if (cfg_default_ready) begin
          arready = ar_en && !fifo_full;
        end else if (arvalid) begin
          if (ar_delay < 2) begin
            ar_state_nx = AR_READY;
          end else begin
            ar_state_nx = AR_WAIT;
            ar_cnt_nx   = ARC_W'(ar_delay - 2);
          end
        end
      end
      AR_WAIT: begin
        if (!arvalid) begin
          ar_state_nx = AR_IDLE;
          ar_cnt_nx   = '0;
        end else if (ar_cnt == '0) begin
          ar_state_nx = AR_READY;
        end else begin
          ar_cnt_nx = ar_cnt - ARC_W'(1);
        end
      end
      AR_READY: begin
        arready = !fifo_full;
        if (arvalid && !fifo_full) ar_state_nx = AR_IDLE;
      end
      default: ar_state_nx = AR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= R_IDLE;
      r_cnt    <= '0;
      cap_pend <= 1'b0;
      rdata    <= '0;
      rresp    <= RRESP_OKAY;
    end else begin
      r_state  <= r_state_nx;
      r_cnt    <= r_cnt_nx;
      cap_pend <= (r_state == R_FETCH);
      if (cap_pend) begin
        rdata <= mem_rd_data;
        rresp <= mem_rd_err ? RRESP_SLVERR : RRESP_OKAY;
      end
    end
  end

  // A same-cycle push counts as non-empty so a fresh read fetches at T+1.
  always_comb begin
    r_state_nx  = r_state;
    r_cnt_nx    = r_cnt;
    pop         = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    r_delay     = clamp_delay(32'(cfg_rvalid_delay), MAX_DELAY_RVALID);
    case (r_state)
      R_IDLE: begin
        if (!fifo_empty || push) r_state_nx = R_FETCH;
      end
      R_FETCH: begin
        pop         = 1'b1;
        mem_rd_en   = 1'b1;
        mem_rd_addr = fifo_head;
        r_cnt_nx    = RC_W'(r_delay);
        r_state_nx  = R_DELAY;
      end
      R_DELAY: begin
        if (r_cnt == '0) r_state_nx = R_VALID;
        else             r_cnt_nx   = r_cnt - RC_W'(1);
      end
      R_VALID: begin
        if (rready) r_state_nx = (!fifo_empty || push) ? R_FETCH : R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

endmodule

// File: doc/axi4_lite_slave_read_scheduler.md
AXI4_LITE_SLAVE_READ_SCHEDULER -- requirements
Module: axi4_lite_slave_read_scheduler

Interface
REQ-001 SHALL take parameter ADDR_WIDTH, default 32: AR address width.
REQ-002 SHALL take parameter DATA_WIDTH, default 32: R data width.
REQ-003 SHALL take parameter DEPTH, default 2: outstanding-read FIFO depth (power of 2, >=2).
REQ-004 SHALL take parameters MAX_DELAY_READY, default 16, and MAX_DELAY_RVALID, default 10: delay clamp limits.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, as the ports below:
  aclk  in  1  clock, rising edge
  areset  in  1  asynchronous active-high reset
  cfg_default_ready  in  1  1 = arready asserted while idle and not full
  cfg_arready_delay  in  5  cycles from arvalid to arready when cfg_default_ready=0
  cfg_rvalid_delay  in  4  extra cycles before rvalid
  arvalid  in  1  AR valid
  araddr  in  ADDR_WIDTH  AR address
  arready  out  1  AR ready
  rvalid  out  1  R valid
  rdata  out  DATA_WIDTH  R data
  rresp  out  2  R response
  rready  in  1  R ready
  mem_rd_en  out  1  one-cycle backing-memory read strobe
  mem_rd_addr  out  ADDR_WIDTH  read address, valid with mem_rd_en
  mem_rd_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en
  mem_rd_err  in  1  error, valid with mem_rd_data
  fifo_level  out  $clog2(DEPTH+1)  queued AR entries

Function
REQ-006 AR FSM SHALL have states AR_IDLE, AR_WAIT, AR_READY.
REQ-007 With cfg_default_ready=1, arready SHALL equal "FIFO not full" in AR_IDLE; handshake pushes araddr the same cycle.
REQ-008 With cfg_default_ready=0: AR_IDLE->AR_WAIT on arvalid; counter loads min(cfg_arready_delay, MAX_DELAY_READY); at 0 -> AR_READY, arready high one cycle if FIFO not full; -> AR_IDLE after handshake.
REQ-009 arvalid deasserted in AR_WAIT SHALL return FSM to AR_IDLE, clear counter, push nothing.
REQ-010 FIFO full SHALL force arready=0 in every state; AR_READY holds until space frees.
REQ-011 R FSM SHALL have states R_IDLE, R_FETCH, R_DELAY, R_VALID.
REQ-012 R_IDLE->R_FETCH when FIFO non-empty; R_FETCH pops the head, drives mem_rd_en=1 and mem_rd_addr, samples min(cfg_rvalid_delay, MAX_DELAY_RVALID) into the delay counter.
REQ-013 Cycle after R_FETCH SHALL capture mem_rd_data into rdata and rresp=2'b10 (SLVERR) if mem_rd_err else 2'b00 (OKAY), entering R_DELAY.
REQ-014 R_DELAY SHALL count down; at 0 -> R_VALID; rvalid registered high in R_VALID.
REQ-015 Latency: AR handshake cycle T, delay D, FIFO previously empty, R FSM idle -> mem_rd_en at T+1, rvalid first high at T+3+D.
REQ-016 rvalid, rdata, rresp SHALL stay stable until rready; on rvalid&&rready -> R_FETCH if FIFO non-empty else R_IDLE (back-to-back, no idle cycle).
REQ-017 FIFO push and pop in the same cycle SHALL both succeed; fifo_level unchanged; pointers wrap modulo DEPTH.
REQ-018 cfg_* changes SHALL affect only transactions whose delay has not yet been sampled.

Reset
REQ-019 areset SHALL asynchronously force both FSMs to IDLE, clear FIFO, counters and pointers; arready=0, rvalid=0, rdata=0, rresp=0, mem_rd_en=0, mem_rd_addr=0, fifo_level=0.
REQ-020 In-flight transactions SHALL be discarded on reset; arready SHALL first rise no earlier than the first aclk edge after areset deasserts.

Structure
REQ-021 RRESP encodings, FSM state enums and default MAX_DELAY_* constants SHALL live in a shared package, axi4_lite_slave_read_sched_pkg.
REQ-022 The outstanding queue SHALL be one sub-module, axi4_lite_sched_fifo (push/pop/full/empty/level).

Verification
REQ-023 default_ready=1, delays 0, single AR addr 0x10, mem data 0xA5A5A5A5 -> arready same cycle, mem_rd_en T+1 addr 0x10, rvalid T+3, rdata 0xA5A5A5A5, rresp 0.
REQ-024 default_ready=0, cfg_arready_delay=31 -> arready 16 cycles after arvalid (clamped); cfg_rvalid_delay=15 -> rvalid at T+13.
REQ-025 DEPTH=2, rready=0, three back-to-back ARs -> fifo_level reaches 2, arready low until first R handshake, no address lost or reordered.
REQ-026 mem_rd_err=1 for the 2nd of two reads -> rresp 0 then 2'b10; rdata stable during 5-cycle rready stall.
REQ-027 arvalid dropped in AR_WAIT -> no push, AR_IDLE; areset pulse in R_DELAY -> all outputs 0 immediately, next AR serviced normally.
